// File: rtl/apb_pkg.sv
// Shared widths and FSM state type for the two-requester APB master.
package apb_pkg;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } state_t;
endpackage

// File: rtl/apb_rr_arb.sv
// Two-input round-robin arbiter; the last-grant register moves only when a grant is accepted.
module apb_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant,
   output logic       idx
);
   logic last;

   always_ff @(posedge clk) begin
      if (rst)
         last <= 1'b1;
      else if (accept)
         last <= idx;
   end

   always_comb begin
      idx = 1'b0;
      if (req == 2'b11)
         idx = ~last;
      else if (req == 2'b10)
         idx = 1'b1;
      grant = '0;
      if (req != 2'b00)
         grant = idx ? 2'b10 : 2'b01;
   end
endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by two requesters: round-robin accept, SETUP/ACCESS/RESP sequencing
// with a PREADY wait-cycle timeout.
module apb_arb_master
   import apb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [1:0]        req_write,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] req_wdata0,
   input  logic [DATA_W-1:0] req_wdata1,
   output logic [1:0]        rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   state_t           state, state_nxt;
   logic [1:0]       grant;
   logic             gidx;
   logic             owner;
   logic             accept;
   logic             timeout_hit;
   logic             done;
   logic [CNT_W-1:0] wait_cnt;

   assign accept      = (state == ST_IDLE) && (req_valid != 2'b00) && !preset;
   assign timeout_hit = (state == ST_ACCESS) && !PREADY && (wait_cnt == CNT_W'(TIMEOUT - 1));
   assign done        = (state == ST_ACCESS) && (PREADY || timeout_hit);

   apb_rr_arb u_arb (
      .clk    (pclk),
      .rst    (preset),
      .req    (req_valid),
      .accept (accept),
      .grant  (grant),
      .idx    (gidx)
   );

   always_ff @(posedge pclk) begin
      if (preset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (req_valid != 2'b00) state_nxt = ST_SETUP;
         ST_SETUP:  state_nxt = ST_ACCESS;
         ST_ACCESS: if (done) state_nxt = ST_RESP;
         ST_RESP:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Handshakes are masked while preset is high so an aborted RESP never pulses.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      PSEL      = 1'b0;
      PENABLE   = 1'b0;
      if (!preset) begin
         unique case (state)
            ST_IDLE:   req_ready = grant;
            ST_SETUP:  PSEL = 1'b1;
            ST_ACCESS: begin
               PSEL    = 1'b1;
               PENABLE = 1'b1;
            end
            ST_RESP:   rsp_valid[owner] = 1'b1;
            default:   ;
         endcase
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         PADDR     <= '0;
         PWDATA    <= '0;
         PWRITE    <= 1'b0;
         owner     <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         if (accept) begin
            PADDR  <= gidx ? req_addr1 : req_addr0;
            PWDATA <= gidx ? req_wdata1 : req_wdata0;
            PWRITE <= req_write[gidx];
            owner  <= gidx;
         end
         if (done) begin
            rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
            rsp_err   <= PREADY ? PSLVERR : 1'b1;
            wait_cnt  <= '0;
         end else if (state == ST_ACCESS) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end else begin
            wait_cnt <= '0;
         end
      end
   end
endmodule
